// File: rtl/bist_diag_collector_if.sv
// Host drain port of the BIST fail log: valid/ready handshake carrying (address, syndrome).
interface bist_diag_collector_if #(
   parameter int unsigned SIZE   = 6,
   parameter int unsigned LENGTH = 8
);
   logic              rd_valid;
   logic              rd_ready;
   logic [SIZE-1:0]   rd_addr;
   logic [LENGTH-1:0] rd_syn;

   modport master (output rd_valid, output rd_addr, output rd_syn, input rd_ready);
   modport slave  (input rd_valid, input rd_addr, input rd_syn, output rd_ready);
endinterface

// File: rtl/bist_diag_collector.sv
// Records failing BIST read-compares as (address, syndrome) entries in a small FIFO for host drain.
// Optional BIST_DIAG_DEDUP_EN: repeat fails at the last-pushed address OR into that entry instead of pushing.
module bist_diag_collector #(
   parameter int unsigned SIZE   = 6,
   parameter int unsigned LENGTH = 8,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned CNTW   = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     bist_active,
   input  logic                     cmp_valid,
   input  logic                     fail,
   input  logic [SIZE-1:0]          fail_addr,
   input  logic [LENGTH-1:0]        expected,
   input  logic [LENGTH-1:0]        actual,
   bist_diag_collector_if.master    rd,
   output logic [CNTW-1:0]          fail_count,
   output logic                     overflow,
   output logic                     pass,
   output logic                     busy
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam logic [CNTW-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]   fail_count_q, fail_count_d;
   logic              overflow_q, overflow_d;
   logic              pass_q, pass_d;
   logic              busy_q, busy_d;
   logic              rd_valid_q, rd_valid_d;
   logic [SIZE-1:0]   rd_addr_q, rd_addr_d;
   logic [LENGTH-1:0] rd_syn_q, rd_syn_d;

   logic [SIZE-1:0]   addr_mem_q [DEPTH];
   logic [LENGTH-1:0] syn_mem_q  [DEPTH];

   logic              record_c, empty_c, full_c, dup_c;
   logic              push_c, merge_c, start_c;
   logic [LENGTH-1:0] syn_c;
   logic [AW-1:0]     last_idx_c;

   assign record_c   = cmp_valid & fail;
   assign syn_c      = expected ^ actual;
   assign empty_c    = (wr_ptr_q == rd_ptr_q);
   assign full_c     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign last_idx_c = wr_ptr_q[AW-1:0] - AW'(1);

`ifdef BIST_DIAG_DEDUP_EN
   logic [SIZE-1:0] last_addr_q;
   logic            last_vld_q;

   assign dup_c = last_vld_q && (fail_addr == last_addr_q);

   // Address of the most recent push; forgotten at every session start.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_vld_q  <= 1'b0;
         last_addr_q <= '0;
      end else if (start_c) begin
         last_vld_q  <= 1'b0;
      end else if (push_c) begin
         last_vld_q  <= 1'b1;
         last_addr_q <= fail_addr;
      end
   end
`else
   assign dup_c = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      fail_count_d = fail_count_q;
      overflow_d   = overflow_q;
      push_c       = 1'b0;
      merge_c      = 1'b0;
      start_c      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bist_active) begin
               state_d = COLLECT;
               start_c = 1'b1;
            end
         end
         COLLECT: begin
            if (record_c) begin
               if (fail_count_q != CNT_MAX) fail_count_d = fail_count_q + CNTW'(1);
               if (dup_c)        merge_c    = !empty_c;
               else if (!full_c) push_c     = 1'b1;
               else              overflow_d = 1'b1;
            end
            if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
            if (!bist_active) state_d = REPORT;
         end
         REPORT: begin
            if (bist_active) begin
               state_d = COLLECT;
               start_c = 1'b1;
            end else if (rd_valid_q && rd.rd_ready) begin
               rd_ptr_d = rd_ptr_q + PW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      // A new session discards the log and counters, including unread entries.
      if (start_c) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         fail_count_d = '0;
         overflow_d   = 1'b0;
      end
      rd_valid_d = (state_q == REPORT) && (state_d == REPORT) && (rd_ptr_d != wr_ptr_d);
      rd_addr_d  = rd_valid_d ? addr_mem_q[rd_ptr_d[AW-1:0]] : rd_addr_q;
      rd_syn_d   = rd_valid_d ? syn_mem_q[rd_ptr_d[AW-1:0]]  : rd_syn_q;
      pass_d     = (state_d == REPORT) && (fail_count_d == '0);
      busy_d     = (state_d == COLLECT);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fail_count_q <= '0;
         overflow_q   <= 1'b0;
         pass_q       <= 1'b0;
         busy_q       <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_addr_q    <= '0;
         rd_syn_q     <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fail_count_q <= fail_count_d;
         overflow_q   <= overflow_d;
         pass_q       <= pass_d;
         busy_q       <= busy_d;
         rd_valid_q   <= rd_valid_d;
         rd_addr_q    <= rd_addr_d;
         rd_syn_q     <= rd_syn_d;
      end
   end

   // Log storage; contents are don't-care while the pointers say empty.
   always_ff @(posedge clk) begin
      if (push_c) begin
         addr_mem_q[wr_ptr_q[AW-1:0]] <= fail_addr;
         syn_mem_q[wr_ptr_q[AW-1:0]]  <= syn_c;
      end else if (merge_c) begin
         syn_mem_q[last_idx_c] <= syn_mem_q[last_idx_c] | syn_c;
      end
   end

   assign rd.rd_valid = rd_valid_q;
   assign rd.rd_addr  = rd_addr_q;
   assign rd.rd_syn   = rd_syn_q;
   assign fail_count  = fail_count_q;
   assign overflow    = overflow_q;
   assign pass        = pass_q;
   assign busy        = busy_q;
endmodule

// File: tb/tb_bist_diag_collector.sv
// Directed bench for bist_diag_collector with a queue-based session model checked every cycle.
module tb_bist_diag_collector;
   logic       clk;
   logic       rst;
   logic       bist_active, cmp_valid, fail;
   logic [5:0] fail_addr;
   logic [7:0] expected, actual;
   logic [9:0] fail_count;
   logic       overflow, pass, busy;

   int n_err = 0;
   int n_chk = 0;

   bist_diag_collector_if #(.SIZE(6), .LENGTH(8)) rd_if ();

   bist_diag_collector #(.SIZE(6), .LENGTH(8), .DEPTH(4), .CNTW(10)) dut (
      .clk(clk), .rst(rst), .bist_active(bist_active), .cmp_valid(cmp_valid), .fail(fail),
      .fail_addr(fail_addr), .expected(expected), .actual(actual), .rd(rd_if),
      .fail_count(fail_count), .overflow(overflow), .pass(pass), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Session model: log as a bounded queue, plain integer fail count.
   typedef struct packed { logic [5:0] a; logic [7:0] s; } ent_t;
   ent_t       mq[$];
   int         m_phase = 0;   // 0 idle, 1 collecting, 2 reporting
   int         m_cnt = 0;
   int         m_age = 0;
   bit         m_ovf = 0, m_rdv = 0, m_live = 0, m_last_v = 0;
   logic [5:0] m_last = '0;

   always @(posedge clk) begin
      ent_t e;
      if (!rst) begin
         m_phase = 0; mq.delete(); m_cnt = 0; m_ovf = 0; m_age = 0; m_last_v = 0;
      end else begin
         case (m_phase)
            0: if (bist_active) begin
                  mq.delete(); m_cnt = 0; m_ovf = 0; m_last_v = 0; m_phase = 1;
               end
            1: begin
                  if (cmp_valid && fail) begin
                     if (m_cnt < 1023) m_cnt++;
                     e.a = fail_addr;
                     e.s = expected ^ actual;
`ifdef BIST_DIAG_DEDUP_EN
                     if (m_last_v && fail_addr == m_last) begin
                        if (mq.size() > 0) begin
                           e.s = mq[mq.size()-1].s | e.s;
                           mq[mq.size()-1] = e;
                        end
                     end else
`endif
                     if (mq.size() < 4) begin
                        mq.push_back(e); m_last = fail_addr; m_last_v = 1;
                     end else m_ovf = 1;
                  end
                  if (!bist_active) begin m_phase = 2; m_age = 0; end
               end
            default: if (bist_active) begin
                  mq.delete(); m_cnt = 0; m_ovf = 0; m_last_v = 0; m_phase = 1;
               end else begin
                  if (m_rdv && rd_if.rd_ready) void'(mq.pop_front());
                  m_age++;
               end
         endcase
      end
      m_rdv  = (m_phase == 2) && (m_age > 0) && (mq.size() > 0);
      m_live = 1;
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("m_rd_valid", 32'(rd_if.rd_valid), 32'(m_rdv));
         chk("m_fail_count", 32'(fail_count), 32'(m_cnt));
         chk("m_overflow", 32'(overflow), 32'(m_ovf));
         chk("m_pass", 32'(pass), 32'((m_phase == 2) && (m_cnt == 0)));
         chk("m_busy", 32'(busy), 32'(m_phase == 1));
         if (m_rdv) begin
            chk("m_rd_addr", 32'(rd_if.rd_addr), 32'(mq[0].a));
            chk("m_rd_syn", 32'(rd_if.rd_syn), 32'(mq[0].s));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ba, input logic cv, input logic f,
                        input logic [5:0] a, input logic [7:0] ex, input logic [7:0] ac);
      bist_active = ba; cmp_valid = cv; fail = f; fail_addr = a; expected = ex; actual = ac;
      step();
   endtask

   task automatic pop_check(input logic [5:0] a, input logic [7:0] s);
      int w = 0;
      while (!rd_if.rd_valid && w < 20) begin step(); w++; end
      chk("pop_valid", 32'(rd_if.rd_valid), 32'd1);
      chk("pop_addr", 32'(rd_if.rd_addr), 32'(a));
      chk("pop_syn", 32'(rd_if.rd_syn), 32'(s));
      rd_if.rd_ready = 1'b1;
      step();
      rd_if.rd_ready = 1'b0;
   endtask

   task automatic chk_reset_vals();
      chk("rst_rd_valid", 32'(rd_if.rd_valid), 32'd0);
      chk("rst_rd_addr", 32'(rd_if.rd_addr), 32'd0);
      chk("rst_rd_syn", 32'(rd_if.rd_syn), 32'd0);
      chk("rst_fail_count", 32'(fail_count), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b0; rd_if.rd_ready = 1'b0;
      bist_active = 0; cmp_valid = 0; fail = 0; fail_addr = '0; expected = '0; actual = '0;
      repeat (3) step();
      chk_reset_vals();
      rst = 1'b1;
      step();

      // Clean session
      repeat (64) drive(1, 1, 0, 6'h2A, 8'h5A, 8'h5A);
      drive(0, 0, 0, '0, '0, '0);
      step();
      chk("clean_pass", 32'(pass), 32'd1);
      chk("clean_count", 32'(fail_count), 32'd0);
      chk("clean_rd_valid", 32'(rd_if.rd_valid), 32'd0);
      chk("clean_busy", 32'(busy), 32'd0);

      // Two fails
      drive(1, 0, 0, '0, '0, '0);
      drive(1, 1, 1, 6'h05, 8'hAA, 8'hAB);
      drive(1, 0, 0, '0, '0, '0);
      drive(1, 1, 1, 6'h21, 8'h55, 8'h15);
      drive(0, 0, 0, '0, '0, '0);
      pop_check(6'h05, 8'h01);
      pop_check(6'h21, 8'h40);
      chk("two_count", 32'(fail_count), 32'd2);
      chk("two_pass", 32'(pass), 32'd0);
      chk("two_empty", 32'(rd_if.rd_valid), 32'd0);

      // Overflow, then backpressure and back-to-back drain
      drive(1, 0, 0, '0, '0, '0);
      for (int i = 1; i <= 6; i++) drive(1, 1, 1, 6'(i), 8'h00, 8'(i));
      drive(0, 0, 0, '0, '0, '0);
      chk("ovf_count", 32'(fail_count), 32'd6);
      chk("ovf_flag", 32'(overflow), 32'd1);
      step();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(rd_if.rd_valid), 32'd1);
         chk("bp_addr", 32'(rd_if.rd_addr), 32'd1);
         chk("bp_syn", 32'(rd_if.rd_syn), 32'd1);
         step();
      end
      rd_if.rd_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("b2b_valid", 32'(rd_if.rd_valid), 32'd1);
         chk("b2b_addr", 32'(rd_if.rd_addr), 32'(i));
         chk("b2b_syn", 32'(rd_if.rd_syn), 32'(i));
         step();
      end
      rd_if.rd_ready = 1'b0;
      chk("b2b_empty", 32'(rd_if.rd_valid), 32'd0);

      // Fail in the cycle bist_active falls
      drive(1, 0, 0, '0, '0, '0);
      drive(0, 1, 1, 6'h33, 8'hF0, 8'h0F);
      pop_check(6'h33, 8'hFF);
      chk("edge_count", 32'(fail_count), 32'd1);
      chk("edge_empty", 32'(rd_if.rd_valid), 32'd0);

      // Restart in REPORT with three unread entries
      drive(1, 0, 0, '0, '0, '0);
      drive(1, 1, 1, 6'h07, 8'h00, 8'h01);
      drive(1, 1, 1, 6'h08, 8'h00, 8'h02);
      drive(1, 1, 1, 6'h09, 8'h00, 8'h03);
      drive(0, 0, 0, '0, '0, '0);
      step();
      chk("rr_valid_before", 32'(rd_if.rd_valid), 32'd1);
      drive(1, 0, 0, '0, '0, '0);
      chk("rr_count", 32'(fail_count), 32'd0);
      chk("rr_valid", 32'(rd_if.rd_valid), 32'd0);
      chk("rr_busy", 32'(busy), 32'd1);
      drive(0, 0, 0, '0, '0, '0);
      step();
      chk("rr_empty", 32'(rd_if.rd_valid), 32'd0);
      chk("rr_pass", 32'(pass), 32'd1);

      // Reset mid-session
      drive(1, 0, 0, '0, '0, '0);
      drive(1, 1, 1, 6'h11, 8'h00, 8'h03);
      drive(1, 1, 1, 6'h12, 8'h00, 8'h05);
      rst = 1'b0;
      drive(1, 0, 0, '0, '0, '0);
      chk_reset_vals();
      rst = 1'b1;
      drive(0, 0, 0, '0, '0, '0);
      step();
      chk("post_rst_busy", 32'(busy), 32'd0);

      // Repeated address
      drive(1, 0, 0, '0, '0, '0);
      drive(1, 1, 1, 6'h0A, 8'h00, 8'h01);
      drive(1, 1, 1, 6'h0A, 8'h00, 8'h80);
      drive(0, 0, 0, '0, '0, '0);
`ifdef BIST_DIAG_DEDUP_EN
      pop_check(6'h0A, 8'h81);
`else
      pop_check(6'h0A, 8'h01);
      pop_check(6'h0A, 8'h80);
`endif
      chk("dup_count", 32'(fail_count), 32'd2);
      chk("dup_empty", 32'(rd_if.rd_valid), 32'd0);

      // Counter saturation
      drive(1, 0, 0, '0, '0, '0);
      repeat (1030) drive(1, 1, 1, 6'h3F, 8'hFF, 8'h00);
      drive(0, 0, 0, '0, '0, '0);
      chk("sat_count", 32'(fail_count), 32'd1023);
`ifdef BIST_DIAG_DEDUP_EN
      chk("sat_overflow", 32'(overflow), 32'd0);
`else
      chk("sat_overflow", 32'(overflow), 32'd1);
`endif
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
